l2_backing_memory: RTL
======================

Name: l2_backing_memory

Overview:
Block-granular main-memory responder at the far end of the L2 cache's memory interface. Accepts one-cycle read or write request pulses for whole L2 blocks and models a configurable access latency. Returns read data with a one-cycle ready/hit pulse. Used as the memory model under the L1/L2 hierarchy in simulation and as the template for the real memory controller.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 32, request address width
BLOCK_SIZE, 16, words per block; must match the L2 block size
MEM_DEPTH_BLOCKS, 256, number of blocks stored; power of two
READ_LATENCY, 4, cycles from request acceptance to response; at least 1
WRITE_LATENCY, 4, cycles from request acceptance to write completion; at least 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_addr  in  ADDR_WIDTH  block address from the L2; block-offset bits ignored
req_wdata  in  BLOCK_SIZE*DATA_WIDTH  write block; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_read  in  1  read request pulse
req_write  in  1  write request pulse
rsp_rdata  out  BLOCK_SIZE*DATA_WIDTH  read block, registered, same packing as req_wdata
rsp_ready  out  1  one-cycle completion pulse
rsp_hit  out  1  completion was in range; valid only with rsp_ready
busy  out  1  request in flight

Behaviour:
- Reset (async): rsp_ready=0, rsp_hit=0, rsp_rdata=0, busy=0, state IDLE, latency counter 0. Storage array is not reset. The bench preloads storage hierarchically.
- Address split: OFF_W=$clog2(BLOCK_SIZE), IDX_W=$clog2(MEM_DEPTH_BLOCKS).
  - Block index = req_addr[OFF_W +: IDX_W].
  - Out of range = any bit of req_addr[ADDR_WIDTH-1 : OFF_W+IDX_W] set.
- States:
  - IDLE:
    - On a clock edge with req_read or req_write high, latch the op, address, req_wdata and in-range flag.
    - Load the counter with the op latency. Go to WAIT. busy=1 from the next cycle.
    - If both req_read and req_write are high, perform the write only; the read is dropped.
  - WAIT:
    - Decrement the counter each cycle.
    - On the edge where the counter reaches its final count, perform the access and go to RESP:
      - Read: rsp_rdata <= stored block.
      - Write: stored block <= latched wdata.
  - RESP:
    - rsp_ready=1 for exactly one cycle; rsp_hit = latched in-range flag.
    - Next edge: go to IDLE, busy=0, rsp_ready=0, rsp_hit=0.
- Timing: request sampled at edge E0. rsp_ready is high between edges E0+L and E0+L+1, where L is READ_LATENCY or WRITE_LATENCY. Back-to-back throughput is one request per L+2 cycles (the request may be accepted at the edge that leaves RESP? no: only in IDLE).
- Requests seen while busy (WAIT or RESP) are ignored, not queued. The L2 never issues them.
- Out-of-range request:
  - Completes with the normal latency, rsp_ready=1, rsp_hit=0.
  - Read: rsp_rdata=0. Write: storage unchanged.
- rsp_rdata holds its last value until the next read completes. Write completions do not change rsp_rdata.
- Read-after-write to the same block returns the new data (the write is committed before the next request is accepted).
- Reset mid-operation: the in-flight request is abandoned, an uncommitted write is not performed, and outputs return to reset values.

Optional Feature:
Macro L2_BACKING_MEMORY_STATS_EN.
- Defined: adds outputs stat_reads, stat_writes and stat_errors, each 16 bits.
  - Saturating counters, incremented on the RESP cycle of a completed in-range read, an in-range write, and any out-of-range request respectively.
  - Cleared by rst_n.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-sim -> rsp_ready=0, rsp_hit=0, rsp_rdata=0, busy=0 immediately (async).
- Read, READ_LATENCY=4: preload block 3 with word i = 0x100+i; pulse req_read with req_addr=0x30 at E0 -> rsp_ready=1, rsp_hit=1 exactly between E4 and E5; rsp_rdata word0=0x100, word15=0x10F.
- Write then read: write block 5 (addr 0x50) with word i = 0xA5A50000+i, wait for rsp_ready, then read 0x50 -> returned data equals the written block; the write completion left rsp_rdata unchanged.
- Simultaneous req_read=1 and req_write=1 to 0x70 with data 0xDEAD_xxxx -> write completes after WRITE_LATENCY; block 7 is updated; exactly one rsp_ready pulse.
- Out of range: read at 0x0001_0000 (MEM_DEPTH_BLOCKS=256) -> rsp_ready=1, rsp_hit=0, rsp_rdata=0 after 4 cycles; a write there leaves all blocks unchanged.
- Busy/reset: a second req_read during WAIT is ignored (one response only); a write to 0x20 aborted by rst_n during WAIT -> block 2 keeps its old contents.

Source files
------------

// File: rtl/l2_backing_memory.sv
// l2_backing_memory: block-granular main-memory responder behind the L2.
// Accepts single-cycle read/write request pulses for whole blocks, waits a
// fixed per-op latency, then commits the access and pulses rsp_ready once.
// Optional statistics outputs are enabled by defining L2_BACKING_MEMORY_STATS_EN.
//
// Handshake: req_read/req_write are one-cycle pulses sampled only while idle
// (busy=0); requests seen while busy are dropped. Every accepted request yields
// exactly one rsp_ready pulse; rsp_hit and rsp_rdata are meaningful only in
// that cycle, and rsp_rdata then holds until the next read completes.
module l2_backing_memory #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int BLOCK_SIZE       = 16,
    parameter int MEM_DEPTH_BLOCKS = 256,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_LATENCY    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req_wdata,
    input  logic                             req_read,
    input  logic                             req_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] rsp_rdata,
    output logic                             rsp_ready,
    output logic                             rsp_hit,
    output logic                             busy,
`ifdef L2_BACKING_MEMORY_STATS_EN
    output logic [15:0]                      stat_reads,
    output logic [15:0]                      stat_writes,
    output logic [15:0]                      stat_errors,
`endif
    output logic [1:0]                       dbg_state
);

    localparam int OFF_W   = $clog2(BLOCK_SIZE);
    localparam int IDX_W   = $clog2(MEM_DEPTH_BLOCKS);
    localparam int BLK_W   = BLOCK_SIZE * DATA_WIDTH;
    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLK_W-1:0]   wdata_q;
    logic               hit_q;

    logic [BLK_W-1:0]   mem [MEM_DEPTH_BLOCKS];

    logic               accept;
    logic               finish;
    logic               in_range;
    logic               mem_we;
    logic               unused_addr_bits;

    // Block-offset bits carry no information for a block-granular memory.
    assign unused_addr_bits = ^req_addr[OFF_W-1:0];
    assign in_range = ~|req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];

    assign accept = (state_q == ST_IDLE) && (req_read || req_write);
    assign finish = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
    // A write commits only when in range; an abort by reset forces IDLE so it never fires.
    assign mem_we = finish && op_write_q && hit_q;

    assign busy      = (state_q != ST_IDLE);
    assign rsp_ready = (state_q == ST_RESP);
    assign rsp_hit   = (state_q == ST_RESP) && hit_q;
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE -> WAIT on a request, WAIT -> RESP on final count, RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: if (finish) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, latency countdown and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            rsp_rdata  <= '0;
        end else if (accept) begin
            // Write wins when both pulses arrive together; the read is dropped.
            op_write_q <= req_write;
            idx_q      <= req_addr[OFF_W +: IDX_W];
            wdata_q    <= req_wdata;
            hit_q      <= in_range;
            cnt_q      <= req_write ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY);
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (finish && !op_write_q) rsp_rdata <= hit_q ? mem[idx_q] : '0;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

`ifdef L2_BACKING_MEMORY_STATS_EN
    // Saturating completion counters, bumped as the RESP cycle closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errors <= '0;
        end else if (state_q == ST_RESP) begin
            if (!hit_q) begin
                if (stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
            end else if (op_write_q) begin
                if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
            end else begin
                if (stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
            end
        end
    end
`endif

endmodule
